// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 set-2 key event decoder.
package ps2_pkg;

  localparam logic [7:0] B_E0 = 8'hE0;
  localparam logic [7:0] B_E1 = 8'hE1;
  localparam logic [7:0] B_F0 = 8'hF0;
  localparam logic [7:0] B_AA = 8'hAA;
  localparam logic [7:0] B_FA = 8'hFA;
  localparam logic [7:0] B_FE = 8'hFE;
  localparam logic [7:0] B_EE = 8'hEE;

  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ALT    = 8'h11;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  localparam int EVT_BRK   = 15;
  localparam int EVT_EXT   = 14;
  localparam int EVT_CAPS  = 13;
  localparam int EVT_CTRL  = 12;
  localparam int EVT_ALT   = 11;
  localparam int EVT_SHIFT = 10;

  typedef logic [2:0] ps2_state_t;
  localparam ps2_state_t ST_IDLE    = 3'd0;
  localparam ps2_state_t ST_EXT     = 3'd1;
  localparam ps2_state_t ST_BRK     = 3'd2;
  localparam ps2_state_t ST_EXT_BRK = 3'd3;
  localparam ps2_state_t ST_PAUSE   = 3'd4;

  localparam logic [2:0] PAUSE_LEN = 3'd7;

  typedef struct packed {
    logic       brk;
    logic       ext;
    logic [7:0] code;
  } key_t;

endpackage

// File: rtl/fifo.sv
// Shared synchronous FIFO; head is shown combinationally, 0 when empty.
module fifo #(
  parameter int D_WIDTH = 16,
  parameter int A_WIDTH = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr,
  input  logic [D_WIDTH-1:0] din,
  input  logic               rd,
  output logic [D_WIDTH-1:0] dout,
  output logic               empty,
  output logic               full,
  output logic [A_WIDTH:0]   count
);

  logic [D_WIDTH-1:0] mem_q [2**A_WIDTH];
  logic [A_WIDTH:0]   wp_q, wp_d;
  logic [A_WIDTH:0]   rp_q, rp_d;
  logic               wr_ok, rd_ok;

  assign count = wp_q - rp_q;
  assign empty = (count == '0);
  assign full  = count[A_WIDTH];
  assign rd_ok = rd && !empty;
  // a full FIFO still accepts a write when the head leaves this cycle
  assign wr_ok = wr && (!full || rd_ok);
  assign dout  = empty ? '0 : mem_q[rp_q[A_WIDTH-1:0]];

  always_comb begin
    wp_d = wp_q + {{A_WIDTH{1'b0}}, wr_ok};
    rp_d = rp_q + {{A_WIDTH{1'b0}}, rd_ok};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wp_q[A_WIDTH-1:0]] <= din;
  end

endmodule

// File: rtl/ps2_ascii_lut.sv
// Set-2 scancode to ASCII; letters follow shift^caps, others shift only.
import ps2_pkg::*;

module ps2_ascii_lut (
  input  logic [7:0] code,
  input  logic       ext,
  input  logic       shift,
  input  logic       caps,
  output logic [7:0] ascii
);

  logic [7:0] lo, hi;
  logic       letter;

  always_comb begin
    lo = 8'h00;
    hi = 8'h00;
    letter = 1'b0;
    case (code)
      8'h1C: begin lo = "a"; letter = 1'b1; end
      8'h32: begin lo = "b"; letter = 1'b1; end
      8'h21: begin lo = "c"; letter = 1'b1; end
      8'h23: begin lo = "d"; letter = 1'b1; end
      8'h24: begin lo = "e"; letter = 1'b1; end
      8'h2B: begin lo = "f"; letter = 1'b1; end
      8'h34: begin lo = "g"; letter = 1'b1; end
      8'h33: begin lo = "h"; letter = 1'b1; end
      8'h43: begin lo = "i"; letter = 1'b1; end
      8'h3B: begin lo = "j"; letter = 1'b1; end
      8'h42: begin lo = "k"; letter = 1'b1; end
      8'h4B: begin lo = "l"; letter = 1'b1; end
      8'h3A: begin lo = "m"; letter = 1'b1; end
      8'h31: begin lo = "n"; letter = 1'b1; end
      8'h44: begin lo = "o"; letter = 1'b1; end
      8'h4D: begin lo = "p"; letter = 1'b1; end
      8'h15: begin lo = "q"; letter = 1'b1; end
      8'h2D: begin lo = "r"; letter = 1'b1; end
      8'h1B: begin lo = "s"; letter = 1'b1; end
      8'h2C: begin lo = "t"; letter = 1'b1; end
      8'h3C: begin lo = "u"; letter = 1'b1; end
      8'h2A: begin lo = "v"; letter = 1'b1; end
      8'h1D: begin lo = "w"; letter = 1'b1; end
      8'h22: begin lo = "x"; letter = 1'b1; end
      8'h35: begin lo = "y"; letter = 1'b1; end
      8'h1A: begin lo = "z"; letter = 1'b1; end
      8'h45: {lo, hi} = {"0", ")"};
      8'h16: {lo, hi} = {"1", "!"};
      8'h1E: {lo, hi} = {"2", "@"};
      8'h26: {lo, hi} = {"3", "#"};
      8'h25: {lo, hi} = {"4", "$"};
      8'h2E: {lo, hi} = {"5", "%"};
      8'h36: {lo, hi} = {"6", "^"};
      8'h3D: {lo, hi} = {"7", "&"};
      8'h3E: {lo, hi} = {"8", "*"};
      8'h46: {lo, hi} = {"9", "("};
      8'h0E: {lo, hi} = {8'h60, 8'h7E};
      8'h4E: {lo, hi} = {"-", "_"};
      8'h55: {lo, hi} = {"=", "+"};
      8'h54: {lo, hi} = {"[", "{"};
      8'h5B: {lo, hi} = {"]", "}"};
      8'h5D: {lo, hi} = {"\\", "|"};
      8'h4C: {lo, hi} = {";", ":"};
      8'h52: {lo, hi} = {"'", "\""};
      8'h41: {lo, hi} = {",", "<"};
      8'h49: {lo, hi} = {".", ">"};
      8'h4A: {lo, hi} = {"/", "?"};
      8'h29: {lo, hi} = {8'h20, 8'h20};
      8'h5A: {lo, hi} = {8'h0D, 8'h0D};
      8'h66: {lo, hi} = {8'h08, 8'h08};
      8'h0D: {lo, hi} = {8'h09, 8'h09};
      8'h76: {lo, hi} = {8'h1B, 8'h1B};
      default: {lo, hi} = 16'h0000;
    endcase
    if (letter) hi = lo - 8'h20;
  end

  always_comb begin
    ascii = 8'h00;
    if (ext) begin
      if (code == 8'h4A) ascii = 8'h2F;
      else if (code == 8'h5A) ascii = 8'h0D;
    end else if (letter) begin
      ascii = (shift ^ caps) ? hi : lo;
    end else begin
      ascii = shift ? hi : lo;
    end
  end

endmodule

// File: rtl/ps2_key_event_decoder.sv
// PS/2 set-2 byte stream to key events (ASCII or raw) queued in a FIFO.
import ps2_pkg::*;

module ps2_key_event_decoder #(
  parameter int FIFO_AW       = 5,
  parameter int OUT_MODE      = 0,
  parameter int REPEAT_FILTER = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         byte_in,
  input  logic               byte_vld,
  input  logic               byte_err,
  input  logic               rd,
  output logic [15:0]        evt,
  output logic               empty,
  output logic               full,
  output logic [FIFO_AW:0]   count,
  output logic [3:0]         mods,
  output logic               ovf,
  input  logic               clr_ovf
);

  ps2_state_t st_q, st_d;
  logic [2:0] skip_q, skip_d;
  key_t       key_q, key_d;
  logic       key_vld_q, key_vld_d;
  // {ralt, lalt, rctrl, lctrl, rshift, lshift}
  logic [5:0] mlr_q, mlr_d;
  logic       caps_q, caps_d;
  logic [8:0] last_q, last_d;
  logic       last_vld_q, last_vld_d;
  logic       ovf_q, ovf_d;
  logic       junk;

  assign junk = (byte_in == B_AA) || (byte_in == B_FA) ||
                (byte_in == B_FE) || (byte_in == B_EE) ||
                (byte_in == 8'h00) || (byte_in == 8'hFF);

  always_comb begin
    st_d = st_q;
    skip_d = skip_q;
    key_d = key_q;
    key_vld_d = 1'b0;
    if (byte_err) begin
      st_d = ST_IDLE;
      skip_d = '0;
    end else if (byte_vld) begin
      key_d = '{brk: 1'b0, ext: 1'b0, code: byte_in};
      case (st_q)
        ST_IDLE: begin
          if (byte_in == B_E0) st_d = ST_EXT;
          else if (byte_in == B_F0) st_d = ST_BRK;
          else if (byte_in == B_E1) begin
            st_d = ST_PAUSE;
            skip_d = PAUSE_LEN;
          end else key_vld_d = !junk;
        end
        ST_EXT: begin
          if (byte_in == B_F0) st_d = ST_EXT_BRK;
          else begin
            st_d = ST_IDLE;
            key_vld_d = 1'b1;
            key_d.ext = 1'b1;
          end
        end
        ST_BRK: begin
          st_d = ST_IDLE;
          key_vld_d = 1'b1;
          key_d.brk = 1'b1;
        end
        ST_EXT_BRK: begin
          st_d = ST_IDLE;
          key_vld_d = 1'b1;
          key_d.brk = 1'b1;
          key_d.ext = 1'b1;
        end
        ST_PAUSE: begin
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) begin
            st_d = ST_IDLE;
            key_vld_d = 1'b1;
            key_d.ext = 1'b1;
            key_d.code = B_E1;
          end
        end
        default: st_d = ST_IDLE;
      endcase
    end
  end

  logic       kb, ke, match, is_rep, drop;
  logic [7:0] kc;
  logic [5:0] hit;
  logic       caps_hit, is_mod, push;
  logic [3:0] mods_d;
  logic [7:0] ascii;
  logic [15:0] evt_in;

  assign kb = key_q.brk;
  assign ke = key_q.ext;
  assign kc = key_q.code;
  assign match = last_vld_q && (last_q == {ke, kc});
  assign is_rep = key_vld_q && !kb && match;
  assign drop = is_rep && (REPEAT_FILTER != 0);

  assign hit[0] = !ke && (kc == SC_LSHIFT);
  assign hit[1] = !ke && (kc == SC_RSHIFT);
  assign hit[2] = !ke && (kc == SC_CTRL);
  assign hit[3] =  ke && (kc == SC_CTRL);
  assign hit[4] = !ke && (kc == SC_ALT);
  assign hit[5] =  ke && (kc == SC_ALT);
  assign caps_hit = !ke && (kc == SC_CAPS);
  assign is_mod = |hit;

  always_comb begin
    mlr_d = mlr_q;
    caps_d = caps_q;
    last_d = last_q;
    last_vld_d = last_vld_q;
    if (key_vld_q) begin
      for (int i = 0; i < 6; i++) begin
        if (hit[i]) mlr_d[i] = !kb;
      end
      if (caps_hit && !kb && !is_rep) caps_d = !caps_q;
      if (!kb && !is_rep) begin
        last_d = {ke, kc};
        last_vld_d = 1'b1;
      end else if (kb && match) begin
        last_vld_d = 1'b0;
      end
    end
  end

  assign mods_d = {caps_d, mlr_d[3] | mlr_d[2],
                   mlr_d[5] | mlr_d[4], mlr_d[1] | mlr_d[0]};
  assign mods = {caps_q, mlr_q[3] | mlr_q[2],
                 mlr_q[5] | mlr_q[4], mlr_q[1] | mlr_q[0]};

  ps2_ascii_lut u_lut (
    .code  (kc),
    .ext   (ke),
    .shift (mods_d[0]),
    .caps  (mods_d[3]),
    .ascii (ascii)
  );

  always_comb begin
    push = 1'b0;
    if (key_vld_q && !drop) begin
      if (OUT_MODE != 0) push = 1'b1;
      else push = !kb && !is_mod && (ascii != 8'h00);
    end
  end

  always_comb begin
    evt_in = '0;
    evt_in[EVT_BRK] = kb;
    evt_in[EVT_EXT] = ke;
    evt_in[EVT_CAPS] = mods_d[3];
    evt_in[EVT_CTRL] = mods_d[2];
    evt_in[EVT_ALT] = mods_d[1];
    evt_in[EVT_SHIFT] = mods_d[0];
    evt_in[7:0] = (OUT_MODE != 0) ? kc : ascii;
  end

  // a clear coinciding with a fresh overflow keeps the flag set
  assign ovf_d = (ovf_q && !clr_ovf) || (push && full && !rd);
  assign ovf = ovf_q;

  fifo #(
    .D_WIDTH (16),
    .A_WIDTH (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr    (push),
    .din   (evt_in),
    .rd    (rd),
    .dout  (evt),
    .empty (empty),
    .full  (full),
    .count (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q <= ST_IDLE;
      skip_q <= '0;
      key_q <= '0;
      key_vld_q <= 1'b0;
      mlr_q <= '0;
      caps_q <= 1'b0;
      last_q <= '0;
      last_vld_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      st_q <= st_d;
      skip_q <= skip_d;
      key_q <= key_d;
      key_vld_q <= key_vld_d;
      mlr_q <= mlr_d;
      caps_q <= caps_d;
      last_q <= last_d;
      last_vld_q <= last_vld_d;
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Directed bench: ASCII/filter, raw/filter and raw/no-filter instances.
module tb_ps2_key_event_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] byte_in = 8'h00;
  logic       byte_vld = 1'b0;
  logic       byte_err = 1'b0;
  logic       rd = 1'b0;
  logic       clr_ovf = 1'b0;

  logic [15:0] evt0, evt1, evt2;
  logic        empty0, empty1, empty2;
  logic        full0, full1, full2;
  logic [5:0]  count0, count1, count2;
  logic [3:0]  mods0, mods1, mods2;
  logic        ovf0, ovf1, ovf2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ps2_key_event_decoder #(.FIFO_AW(5), .OUT_MODE(0), .REPEAT_FILTER(1)) u0 (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_vld(byte_vld),
    .byte_err(byte_err), .rd(rd), .evt(evt0), .empty(empty0),
    .full(full0), .count(count0), .mods(mods0), .ovf(ovf0),
    .clr_ovf(clr_ovf));

  ps2_key_event_decoder #(.FIFO_AW(5), .OUT_MODE(1), .REPEAT_FILTER(1)) u1 (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_vld(byte_vld),
    .byte_err(byte_err), .rd(rd), .evt(evt1), .empty(empty1),
    .full(full1), .count(count1), .mods(mods1), .ovf(ovf1),
    .clr_ovf(clr_ovf));

  ps2_key_event_decoder #(.FIFO_AW(5), .OUT_MODE(1), .REPEAT_FILTER(0)) u2 (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_vld(byte_vld),
    .byte_err(byte_err), .rd(rd), .evt(evt2), .empty(empty2),
    .full(full2), .count(count2), .mods(mods2), .ovf(ovf2),
    .clr_ovf(clr_ovf));

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    byte_in = b;
    byte_vld = 1'b1;
    @(negedge clk);
    byte_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop();
    @(negedge clk);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    idle(2);
    chk("rst_empty", 16'(empty0), 16'h1);
    chk("rst_full", 16'(full0), 16'h0);
    chk("rst_count", 16'(count0), 16'h0);
    chk("rst_ovf", 16'(ovf0), 16'h0);
    chk("rst_mods", 16'(mods0), 16'h0);
    chk("rst_evt", evt0, 16'h0000);
    rst = 1'b0;

    // plain press/release, with push latency
    send(8'h1C);
    chk("lat_empty_n1", 16'(empty0), 16'h1);
    idle(1);
    chk("lat_count_n2", 16'(count0), 16'h1);
    send(8'hF0);
    send(8'h1C);
    idle(2);
    chk("a_count", 16'(count0), 16'h1);
    chk("a_evt", evt0, 16'h0061);
    chk("raw_count", 16'(count1), 16'h2);
    chk("raw_make", evt1, 16'h001C);
    pop();
    chk("raw_break", evt1, 16'h801C);
    do_reset();

    // shift, then caps lock
    send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C);
    send(8'hF0); send(8'h12); send(8'h58); send(8'hF0);
    send(8'h58); send(8'h1C);
    idle(2);
    chk("sc_count", 16'(count0), 16'h2);
    chk("shift_A", evt0, 16'h0441);
    pop();
    chk("caps_A", evt0, 16'h2041);
    chk("sc_mods", 16'(mods0), 16'h8);
    do_reset();

    // typematic repeats
    send(8'h1C); send(8'h1C); send(8'h1C);
    send(8'hF0); send(8'h1C);
    idle(2);
    chk("rep_f_count", 16'(count1), 16'h2);
    chk("rep_nf_count", 16'(count2), 16'h4);
    chk("rep_f_make", evt1, 16'h001C);
    pop();
    chk("rep_f_break", evt1, 16'h801C);
    chk("rep_nf_cnt_pop", 16'(count2), 16'h3);
    do_reset();

    // extended keys and the Pause sequence
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    idle(2);
    chk("ext_count", 16'(count1), 16'h3);
    chk("ext_make", evt1, 16'h4075);
    pop();
    chk("ext_break", evt1, 16'hC075);
    pop();
    chk("pause_evt", evt1, 16'h40E1);
    pop();
    chk("ext_drained", 16'(empty1), 16'h1);
    chk("ext_ascii_none", 16'(count0), 16'h0);
    send(8'h1C);
    idle(2);
    chk("post_pause_raw", evt1, 16'h001C);
    chk("post_pause_a", evt0, 16'h0061);
    do_reset();

    // overflow and full-FIFO simultaneous push/pop
    for (int i = 0; i < 33; i++) begin
      send(8'h1C); send(8'hF0); send(8'h1C);
    end
    idle(2);
    chk("fill_full", 16'(full0), 16'h1);
    chk("fill_ovf", 16'(ovf0), 16'h1);
    chk("fill_count", 16'(count0), 16'd32);
    @(negedge clk);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    chk("clr_ovf", 16'(ovf0), 16'h0);
    @(negedge clk);
    byte_in = 8'h32;
    byte_vld = 1'b1;
    @(negedge clk);
    byte_vld = 1'b0;
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    chk("pp_count", 16'(count0), 16'd32);
    chk("pp_full", 16'(full0), 16'h1);
    chk("pp_ovf", 16'(ovf0), 16'h0);
    for (int i = 0; i < 31; i++) pop();
    chk("pp_last_cnt", 16'(count0), 16'h1);
    chk("pp_last_evt", evt0, 16'h0062);
    do_reset();

    // receiver errors
    send(8'hE0);
    @(negedge clk);
    byte_err = 1'b1;
    @(negedge clk);
    byte_err = 1'b0;
    send(8'h1C);
    idle(2);
    chk("err_count", 16'(count1), 16'h1);
    chk("err_noext", evt1, 16'h001C);
    send(8'hE0);
    @(negedge clk);
    byte_err = 1'b1;
    byte_vld = 1'b1;
    byte_in = 8'hF0;
    @(negedge clk);
    byte_err = 1'b0;
    byte_vld = 1'b0;
    send(8'h32);
    idle(2);
    chk("errvld_count", 16'(count1), 16'h2);
    pop();
    chk("errvld_evt", evt1, 16'h0032);
    do_reset();

    // reset in the middle of a sequence
    send(8'h12);
    send(8'hE0);
    idle(1);
    chk("mid_mods_pre", 16'(mods0), 16'h1);
    do_reset();
    chk("mid_empty", 16'(empty0), 16'h1);
    chk("mid_empty_raw", 16'(empty1), 16'h1);
    chk("mid_mods", 16'(mods0), 16'h0);
    send(8'h1C);
    idle(2);
    chk("mid_a", evt0, 16'h0061);
    chk("mid_raw", evt1, 16'h001C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_key_event_decoder.md
Name: ps2_key_event_decoder

Overview:
- Converts the PS/2 set-2 scancode byte stream from the PS/2 device-to-host receiver into key events and queues them in a parametrised FIFO.
- Sits between the PS/2 receiver and the CPU/console consumer.
- Handles E0-extended and E1 (Pause) sequences, make/break tracking, left/right modifiers, Caps Lock toggling, and optional typematic-repeat suppression.
- Has two output modes: ASCII (printable key presses only) or raw events (every make and break).

Parameters:
FIFO_AW, 5, FIFO address width; depth = 2**FIFO_AW entries.
OUT_MODE, 0, 0 = ASCII mode (press events with a non-zero ASCII value only); 1 = raw event mode (all make and break events).
REPEAT_FILTER, 1, 1 = drop typematic repeat makes; 0 = pass them through.

Ports:
clk  in  1  system clock
rst  in  1  reset; rst, asynchronous, active-high; clock clk
byte_in  in  8  received scancode byte
byte_vld  in  1  one-cycle strobe; byte_in is valid
byte_err  in  1  one-cycle strobe; receiver framing or parity error
rd  in  1  pop strobe for the FIFO head
evt  out  16  FIFO head (see format below)
empty  out  1  FIFO empty
full  out  1  FIFO full
count  out  FIFO_AW+1  number of entries in the FIFO
mods  out  4  live modifier state {caps_lock, ctrl, alt, shift}
ovf  out  1  sticky overflow flag
clr_ovf  in  1  clears ovf

Behaviour:
- evt format:
  - [15] break
  - [14] extended (E0 or E1 prefix)
  - [13] caps_lock
  - [12] ctrl
  - [11] alt
  - [10] shift
  - [9:8] 0
  - [7:0] ASCII byte (OUT_MODE=0) or scancode (OUT_MODE=1)
- Modifier bits in evt are sampled after the current key has been applied to the modifier state.
- Reset values: empty=1, full=0, count=0, ovf=0, mods=0, evt=0. Parser is in IDLE, last_make is invalid, and all modifier registers are 0.
- Parser FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen), PAUSE (skip counter).
  - IDLE: E0->EXT, F0->BRK, E1->PAUSE with skip=7; any other byte completes a make with ext=0.
  - EXT: F0->EXT_BRK; any other byte completes a make with ext=1.
  - BRK: next byte completes a break with ext=0.
  - EXT_BRK: next byte completes a break with ext=1.
  - PAUSE: decrement skip on each byte. At 0, return to IDLE and complete a make with code E1, ext=1.
- Byte handling:
  - Bytes AA (BAT OK), FA (ACK), FE (resend), EE (echo) and 00/FF (error) received in IDLE are discarded without an event.
  - byte_err forces IDLE (skip cleared) in the same cycle and produces no event. If byte_err and byte_vld arrive together, byte_err wins.
- Modifier state:
  - Tracked separately for L/R: shift 12/59; ctrl 14/E0 14; alt 11/E0 11.
  - mods.shift = lshift|rshift; ctrl and alt are formed the same way.
  - Make sets the bit; break clears it.
  - Caps Lock (58) toggles on a non-repeat make only; its break changes nothing.
- Repeat filter:
  - last_make holds {ext, code} of the most recent make.
  - A make equal to last_make with no intervening break is a repeat.
  - Repeats are dropped if REPEAT_FILTER=1; a dropped repeat does not toggle Caps Lock.
  - A break whose {ext, code} matches last_make invalidates last_make.
- Emission:
  - OUT_MODE=0: emit only non-break, non-modifier events whose ASCII value is non-zero.
  - ASCII uses shift XOR caps_lock for letters and shift alone for other keys.
  - ext keys use ASCII only for keypad "/" (E0 4A -> 2F) and keypad Enter (E0 5A -> 0D); all other ext keys map to 0 and are dropped.
  - OUT_MODE=1: emit every make and break, including modifiers; the dropped repeats above are not emitted.
- Latency: final byte_vld in cycle N -> push in cycle N+1 -> empty=0 and count updated from cycle N+2.
- FIFO rules:
  - rd while empty: ignored.
  - Push while full without rd: event dropped and ovf set (sticky until clr_ovf). clr_ovf and a new overflow in the same cycle leave ovf=1.
  - Push and rd in the same cycle while full: both succeed, count unchanged.
  - evt shows the head entry combinationally; a pop takes effect at the next clock edge.
- Reset mid-sequence: a partial sequence is abandoned, the FIFO is flushed, and modifiers are cleared.

Decomposition:
- Package ps2_pkg holds:
  - byte constants: E0, E1, F0, AA, FA, FE, EE
  - modifier scancodes
  - evt bit-index constants
  - parser state enum
  - PAUSE_LEN=7
- Sub-module ps2_ascii_lut: combinational; inputs code, ext, shift, caps; output ascii.
- The FIFO is the existing shared fifo with D_WIDTH=16, A_WIDTH=FIFO_AW.

Test Plan:
- OUT_MODE=0: bytes 1C, F0, 1C -> exactly one entry with evt[7:0]=61 ('a') and evt[15:10]=0; count=1, observed 2 cycles after the last 1C strobe of the first byte's push.
- 12, 1C, F0 1C, F0 12, then 58, F0 58, 1C -> entries 41 ('A', shift=1), then 41 with caps=1, shift=0. mods=1000 at the end.
- REPEAT_FILTER=1, OUT_MODE=1: 1C, 1C, 1C, F0 1C -> two entries: 001C and 801C. With REPEAT_FILTER=0 -> four entries.
- OUT_MODE=1: E0 75, E0 F0 75, E1 14 77 E1 F0 14 F0 77 -> entries 4075, C075, 40E1; parser in IDLE afterwards.
- Fill 2**FIFO_AW+1 presses without rd -> full=1, ovf=1, count=32 (default). clr_ovf clears ovf. rd and push in the same cycle while full -> count stays 32.
- byte_err after E0, then 1C -> entry with ext=0. Assert rst after 12 E0 -> empty=1, mods=0, and the next 1C yields 'a'.
